// File: rtl/v2_trap_filter_pkg.sv
// Shared settings for the v2 trapezoid shaper.
// Default widths, reset config and FSM state type.
package package_settings_V2;

  localparam int DEF_IN_W  = 14;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_CNT_W = 7;
  localparam int DEF_M_W   = 10;
  localparam int DEF_ACC_W = 40;

  localparam int RST_K     = 4;
  localparam int RST_L     = 8;
  localparam int RST_M     = 0;
  localparam int RST_SHIFT = 0;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

endpackage

// File: rtl/v2_trap_filter_delay.sv
// Sample history shift register, newest at index 0.
// Ports: clk, rst_n, clr_i, en_i, din_i, k_i, l_i -> tap_k_o, tap_l_o, tap_kl_o.
module trap_delay_line #(
  parameter int DEPTH = 64,
  parameter int W     = 14,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [W-1:0]     din_i,
  input  logic [CNT_W-1:0] k_i,
  input  logic [CNT_W-1:0] l_i,
  output logic [W-1:0]     tap_k_o,
  output logic [W-1:0]     tap_l_o,
  output logic [W-1:0]     tap_kl_o
);

  logic [W-1:0]     line_q [DEPTH];
  logic [CNT_W-1:0] kl;

  assign kl = k_i + l_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (en_i) begin
      line_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  // Full-width index compare keeps every tap legal for any k/l.
  always_comb begin
    tap_k_o  = '0;
    tap_l_o  = '0;
    tap_kl_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) == k_i) tap_k_o = line_q[i];
      if (CNT_W'(i) == l_i) tap_l_o = line_q[i];
      if (CNT_W'(i) == kl)  tap_kl_o = line_q[i];
    end
  end

endmodule

// File: rtl/v2_trap_filter.sv
// k/l trapezoid shaper with pole-zero correction, fill FSM, rounding, saturation.
// In: clk, reset(n), en, in_valid/in_data, cfg_*; out: cfg_err, busy, out_valid/data, out_sat.
module v2_trap_filter
  import package_settings_V2::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int M_W   = DEF_M_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_k,
  input  logic [CNT_W-1:0] cfg_l,
  input  logic [M_W-1:0]   cfg_m,
  input  logic [4:0]       cfg_shift,
  output logic             cfg_err,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam logic signed [ACC_W-1:0] OMAX =
    (ACC_W'(1) <<< (OUT_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

  state_t state_q, state_d;

  logic [CNT_W-1:0] k_q, l_q, cnt_q, kl;
  logic [M_W-1:0]   m_q;
  logic [4:0]       sh_q;
  logic             cfg_err_q;

  logic cfg_good, cfg_ok, flush, accept;
  logic run_acc, fill_done;

  logic [IN_W-1:0] tap_k, tap_l, tap_kl, x1_q;
  logic            v1_q, v2_q, v3_q, v4_q;

  logic signed [IN_W+1:0]  d_d, d_q;
  logic signed [ACC_W-1:0] d_ext, m_ext;
  logic signed [ACC_W-1:0] p_q, p_d, r_q, r_d, s_q;
  logic signed [ACC_W-1:0] rnd, sum, shv;
  logic [OUT_W-1:0]        out_val;
  logic                    sat_hit;

  logic             out_valid_q, out_sat_q;
  logic [OUT_W-1:0] out_data_q;

  assign cfg_good = (cfg_k != '0) && (cfg_k <= cfg_l) &&
    (({1'b0, cfg_k} + {1'b0, cfg_l}) <= (CNT_W+1)'(DEPTH-1));
  assign cfg_ok = cfg_load && cfg_good;

  // Everything is held clear while idle, disabled or reconfiguring.
  assign flush  = !en || cfg_ok || (state_q == IDLE);
  assign accept = in_valid && en && !cfg_ok && (state_q != IDLE);

  assign kl        = k_q + l_q;
  assign run_acc   = accept && (state_q == RUN);
  assign fill_done = accept && (state_q == FILL) &&
                     ((cnt_q + CNT_W'(1)) == kl);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (cfg_ok) begin
      state_d = FILL;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (fill_done) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q       <= CNT_W'(RST_K);
      l_q       <= CNT_W'(RST_L);
      m_q       <= M_W'(RST_M);
      sh_q      <= 5'(RST_SHIFT);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_load && !cfg_good;
      if (cfg_ok) begin
        k_q  <= cfg_k;
        l_q  <= cfg_l;
        m_q  <= cfg_m;
        sh_q <= cfg_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (flush)  cnt_q <= '0;
    else if (accept && state_q == FILL)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  trap_delay_line #(
    .DEPTH (DEPTH),
    .W     (IN_W),
    .CNT_W (CNT_W)
  ) u_dl (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (flush),
    .en_i     (accept),
    .din_i    (in_data),
    .k_i      (k_q),
    .l_i      (l_q),
    .tap_k_o  (tap_k),
    .tap_l_o  (tap_l),
    .tap_kl_o (tap_kl)
  );

  assign d_d = $signed({2'b00, x1_q})
             - $signed({2'b00, tap_k})
             - $signed({2'b00, tap_l})
             + $signed({2'b00, tap_kl});

  assign d_ext = {{(ACC_W-IN_W-2){d_q[IN_W+1]}}, d_q};
  assign m_ext = {{(ACC_W-M_W){1'b0}}, m_q};
  assign p_d   = p_q + d_ext;
  assign r_d   = p_d + m_ext * d_ext;

  // Only samples taken in RUN enter the arithmetic pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
      x1_q <= '0;
      d_q  <= '0;
      p_q  <= '0;
      r_q  <= '0;
      s_q  <= '0;
    end else begin
      v1_q <= run_acc;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
      if (run_acc) x1_q <= in_data;
      if (v1_q) d_q <= d_d;
      if (v2_q) begin
        p_q <= p_d;
        r_q <= r_d;
      end
      if (v3_q) s_q <= s_q + r_q;
    end
  end

  assign rnd = (sh_q == 5'd0) ? '0 :
               (ACC_W'(1) << (sh_q - 5'd1));
  assign sum = s_q + rnd;
  assign shv = sum >>> sh_q;

  always_comb begin
    sat_hit = 1'b0;
    out_val = shv[OUT_W-1:0];
    if (shv > OMAX) begin
      sat_hit = 1'b1;
      out_val = OMAX[OUT_W-1:0];
    end else if (shv < OMIN) begin
      sat_hit = 1'b1;
      out_val = OMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= v4_q;
      if (v4_q) begin
        out_data_q <= out_val;
        if (sat_hit) out_sat_q <= 1'b1;
      end
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
